// File: rtl/rs_dsp_pkg.sv
// Shared types and helpers for the DSP38 dot-product accumulator.
// Optional saturation is selected by RS_DSP_ACC_SAT_EN (see rs_dsp_acc_add).
package rs_dsp_pkg;

    localparam int unsigned PROD_W = 38;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    // Extends to PROD_W+1 bits with a correct sign bit; the caller widens the
    // result to ACC_W with a signed cast.
    function automatic logic [PROD_W:0] ext_prod(input logic [PROD_W-1:0] z,
                                                 input logic              is_signed);
        return {is_signed & z[PROD_W-1], z};
    endfunction

endpackage

// File: rtl/rs_dsp_dotprod_accum_if.sv
// Product-in / result-out handshake bundle for rs_dsp_dotprod_accum.
// Optional saturation is selected by RS_DSP_ACC_SAT_EN (no effect on this file).
interface rs_dsp_dotprod_accum_if #(
    parameter int unsigned ACC_W = 64,
    parameter int unsigned LEN_W = 8
);
    import rs_dsp_pkg::*;

    logic [PROD_W-1:0] z_in;
    logic              z_signed;
    logic              z_valid;
    logic              z_ready;
    logic [LEN_W-1:0]  len;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_ovf;
    logic              acc_valid;
    logic              acc_ready;

    modport master (
        output z_in, z_signed, z_valid, len, acc_ready,
        input  z_ready, acc_out, acc_ovf, acc_valid
    );

    modport slave (
        input  z_in, z_signed, z_valid, len, acc_ready,
        output z_ready, acc_out, acc_ovf, acc_valid
    );

endinterface

// File: rtl/rs_dsp_acc_add.sv
// Combinational ACC_W two's-complement adder with signed-overflow detect.
// With RS_DSP_ACC_SAT_EN defined the sum clamps to the signed limits on overflow.
module rs_dsp_acc_add #(
    parameter int unsigned ACC_W = 64
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W-1:0] raw;

    always_comb begin
        raw = a + b;
        ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
`ifdef RS_DSP_ACC_SAT_EN
        // Overflow direction follows the common operand sign.
        if (ovf) begin
            sum = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sum = raw;
        end
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/rs_dsp_dotprod_accum.sv
// Dot-product accumulator over the DSP38 product stream with a valid/ready result.
// Saturating arithmetic when RS_DSP_ACC_SAT_EN is defined, wrap-around otherwise.
module rs_dsp_dotprod_accum
    import rs_dsp_pkg::*;
#(
    parameter int unsigned ACC_W = 64,
    parameter int unsigned LEN_W = 8
) (
    input logic                   clk,
    input logic                   reset,
    rs_dsp_dotprod_accum_if.slave bus
);

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [LEN_W-1:0]  rem_q, rem_d;

    logic [PROD_W:0]   z_ext39;
    logic [ACC_W-1:0]  z_ext;
    logic [ACC_W-1:0]  add_sum;
    logic              add_ovf;

    assign z_ext39 = ext_prod(bus.z_in, bus.z_signed);
    assign z_ext   = ACC_W'($signed(z_ext39));

    rs_dsp_acc_add #(.ACC_W(ACC_W)) u_add (
        .a   (acc_q),
        .b   (z_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
        end
    end

    // z_ready is 1 in IDLE/ACCUM, so z_valid alone marks an accepted beat there.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (bus.z_valid) begin
                    acc_d   = z_ext;
                    ovf_d   = 1'b0;
                    rem_d   = (bus.len == '0) ? '0 : bus.len - LEN_W'(1);
                    state_d = (bus.len <= LEN_W'(1)) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (bus.z_valid) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_ovf;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.acc_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.z_ready   = !reset && (state_q != HOLD);
    assign bus.acc_valid = (state_q == HOLD);
    assign bus.acc_out   = acc_q;
    assign bus.acc_ovf   = ovf_q;

endmodule

// File: tb/tb_rs_dsp_dotprod_accum.sv
// Scoreboard bench: a 64-bit and a 39-bit instance; expected results are queued
// by the stimulus and popped by per-instance monitors on each result handshake.
module tb_rs_dsp_dotprod_accum;

    typedef struct {
        logic [63:0] val;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int unsigned tests = 0;
    int unsigned fails = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    rs_dsp_dotprod_accum_if #(.ACC_W(64), .LEN_W(8)) ifa ();
    rs_dsp_dotprod_accum_if #(.ACC_W(39), .LEN_W(8)) ifb ();

    rs_dsp_dotprod_accum #(.ACC_W(64), .LEN_W(8)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    rs_dsp_dotprod_accum #(.ACC_W(39), .LEN_W(8)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: compare against the queue head on every valid cycle, pop on handshake.
    always @(negedge clk) begin
        if (!reset && ifa.acc_valid) begin
            check("a_zready_in_hold", 64'(ifa.z_ready), 64'd0);
            if (qa.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL a_unexpected_result: got %h expected none", ifa.acc_out);
            end else begin
                check("a_acc_out", ifa.acc_out, qa[0].val);
                check("a_acc_ovf", 64'(ifa.acc_ovf), 64'(qa[0].ovf));
                if (ifa.acc_ready) void'(qa.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && ifb.acc_valid) begin
            check("b_zready_in_hold", 64'(ifb.z_ready), 64'd0);
            if (qb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_unexpected_result: got %h expected none", ifb.acc_out);
            end else begin
                check("b_acc_out", 64'(ifb.acc_out), 64'(qb[0].val[38:0]));
                check("b_acc_ovf", 64'(ifb.acc_ovf), 64'(qb[0].ovf));
                if (ifb.acc_ready) void'(qb.pop_front());
            end
        end
    end

    task automatic beat(input bit sel, input logic [37:0] z, input logic s, input logic [7:0] l);
        int unsigned n;
        logic r;
        n = 0;
        if (!sel) begin
            ifa.z_in = z; ifa.z_signed = s; ifa.len = l; ifa.z_valid = 1'b1;
        end else begin
            ifb.z_in = z; ifb.z_signed = s; ifb.len = l; ifb.z_valid = 1'b1;
        end
        forever begin
            @(negedge clk);
            r = sel ? ifb.z_ready : ifa.z_ready;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 50) begin
                tests++;
                fails++;
                $display("FAIL beat_timeout: got no z_ready expected z_ready within 50 cycles");
                break;
            end
        end
        if (!sel) ifa.z_valid = 1'b0;
        else      ifb.z_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        ifa.z_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [63:0] v, input logic o);
        exp_t e;
        e.val = v;
        e.ovf = o;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [63:0] v, input logic o);
        exp_t e;
        e.val = v;
        e.ovf = o;
        qb.push_back(e);
    endtask

    initial begin
        int unsigned n;
        reset = 1'b1;
        ifa.z_in = '0; ifa.z_signed = 1'b0; ifa.z_valid = 1'b0; ifa.len = '0; ifa.acc_ready = 1'b1;
        ifb.z_in = '0; ifb.z_signed = 1'b0; ifb.z_valid = 1'b0; ifb.len = '0; ifb.acc_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_acc_out", ifa.acc_out, 64'd0);
        check("rst_acc_valid", 64'(ifa.acc_valid), 64'd0);
        check("rst_acc_ovf", 64'(ifa.acc_ovf), 64'd0);
        check("rst_z_ready", 64'(ifa.z_ready), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic signed vector; result must be valid the cycle after the last beat.
        push_a(64'd13, 1'b0);
        beat(0, 38'd5, 1'b1, 8'd3);
        beat(0, 38'h3F_FFFF_FFFE, 1'b1, 8'd3);
        beat(0, 38'd10, 1'b1, 8'd3);
        check("t1_valid_latency", 64'(ifa.acc_valid), 64'd1);

        // len=0 behaves as len=1, unsigned product zero-extends.
        push_a(64'h0000_003F_FFFF_FFFF, 1'b0);
        beat(0, 38'h3F_FFFF_FFFF, 1'b0, 8'd0);
        check("t2_valid_latency", 64'(ifa.acc_valid), 64'd1);

        // Signed -1 + -1 sign-extends across the full accumulator.
        push_a(64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        beat(0, 38'h3F_FFFF_FFFF, 1'b1, 8'd2);
        beat(0, 38'h3F_FFFF_FFFF, 1'b1, 8'd2);

        // 39-bit instance: overflow in both directions, stickiness, clear on next vector.
`ifdef RS_DSP_ACC_SAT_EN
        push_b(64'h3F_FFFF_FFFF, 1'b1);
        push_b(64'h40_0000_0000, 1'b1);
        push_b(64'h3F_FFFF_FFFF, 1'b1);
`else
        push_b(64'h7F_FFFF_FFFE, 1'b1);
        push_b(64'h20_0000_0000, 1'b1);
        push_b(64'h7F_FFFF_FFFF, 1'b1);
`endif
        push_b(64'd5, 1'b0);
        beat(1, 38'h3F_FFFF_FFFF, 1'b0, 8'd2);
        beat(1, 38'h3F_FFFF_FFFF, 1'b0, 8'd2);
        repeat (3) beat(1, 38'h20_0000_0000, 1'b1, 8'd3);
        beat(1, 38'h3F_FFFF_FFFF, 1'b0, 8'd3);
        beat(1, 38'h3F_FFFF_FFFF, 1'b0, 8'd3);
        beat(1, 38'd1, 1'b0, 8'd3);
        beat(1, 38'd5, 1'b1, 8'd1);

        // Backpressure: result held 5+ cycles while the next beat waits upstream.
        ifa.acc_ready = 1'b0;
        push_a(64'd300, 1'b0);
        beat(0, 38'd100, 1'b0, 8'd2);
        beat(0, 38'd200, 1'b0, 8'd2);
        push_a(64'd7, 1'b0);
        fork
            beat(0, 38'd7, 1'b0, 8'd1);
            begin
                repeat (5) @(posedge clk);
                #1;
                check("bp_no_accept_in_hold", 64'(ifa.acc_out), 64'd300);
                ifa.acc_ready = 1'b1;
                @(posedge clk);
                #1;
                ifa.acc_ready = 1'b0;
            end
        join
        check("bp_next_vector_valid", 64'(ifa.acc_valid), 64'd1);
        ifa.acc_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-vector discards the partial sum.
        beat(0, 38'd11, 1'b0, 8'd4);
        beat(0, 38'd22, 1'b0, 8'd4);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_z_ready", 64'(ifa.z_ready), 64'd0);
        @(posedge clk);
        #1;
        check("midrst_acc_out", ifa.acc_out, 64'd0);
        check("midrst_acc_valid", 64'(ifa.acc_valid), 64'd0);
        reset = 1'b0;
        repeat (2) idle_cycle();
        check("midrst_still_idle", 64'(ifa.acc_valid), 64'd0);
        push_a(64'd7, 1'b0);
        beat(0, 38'd7, 1'b0, 8'd1);

        // Gaps in z_valid; len on later beats must be ignored.
        push_a(64'd10, 1'b0);
        beat(0, 38'd1, 1'b0, 8'd4);
        idle_cycle();
        idle_cycle();
        beat(0, 38'd2, 1'b0, 8'd1);
        beat(0, 38'd3, 1'b0, 8'd0);
        idle_cycle();
        check("gap_not_done_early", 64'(ifa.acc_valid), 64'd0);
        beat(0, 38'd4, 1'b0, 8'd9);

        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
        end
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rs_dsp_dotprod_accum.md
Name: rs_dsp_dotprod_accum

Overview:
- Downstream consumer of the 20x18 DSP38 multiplier's 38-bit product stream.
- Accumulates a programmable-length sequence of products into a wide signed accumulator, i.e. a dot product.
- Presents the result on a valid/ready output interface.
- Sits between the combinational multiplier wrapper and the fabric result FIFO / writeback logic.

Parameters:
- ACC_W, 64, accumulator and result width; must be >= 39.
- LEN_W, 8, width of the vector-length input.

Ports:
- clk  input  1  clock; all logic rising-edge.
- reset  input  1  synchronous reset, active-high.
- z_in  input  38  product from multiplier.
- z_signed  input  1  1 = product is signed (either operand signed); 0 = both operands unsigned.
- z_valid  input  1  product beat valid.
- z_ready  output  1  block can accept a beat.
- len  input  LEN_W  products per dot product; sampled on first beat; 0 treated as 1.
- acc_out  output  ACC_W  accumulated result, registered.
- acc_ovf  output  1  overflow occurred during this vector; sticky per vector.
- acc_valid  output  1  result valid.
- acc_ready  input  1  consumer accepts result.

Behaviour:
- One clock domain. Reset is synchronous and active-high: every register clears on the rising clk edge with reset=1.
- Reset values: state=IDLE, acc_out=0, acc_ovf=0, acc_valid=0, rem=0. z_ready=0 while reset is high.
- A beat is accepted when z_valid & z_ready. A result is taken when acc_valid & acc_ready.
- Product extension to ACC_W:
  - z_signed=1: sign-extend from bit 37.
  - z_signed=0: zero-extend.
  - The accumulator is always two's-complement signed.
- FSM:
  - IDLE: z_ready=1, acc_valid=0. On a beat: acc<=ext(z_in), acc_ovf<=0, rem<=max(len,1)-1. Go to HOLD if max(len,1)==1, else ACCUM.
  - ACCUM: z_ready=1. On a beat: acc<=acc+ext(z_in), rem<=rem-1. If rem==1 before the decrement, go to HOLD. No beat: hold all state.
  - HOLD: z_ready=0, acc_valid=1, acc_out stable. On acc_ready: go to IDLE, acc_valid<=0.
- Latency:
  - Result is valid the cycle after the last beat is accepted.
  - Minimum one idle-accept cycle between vectors; the HOLD->IDLE transition takes one cycle even when acc_ready was high on HOLD entry.
- len is ignored outside the first-beat cycle. Changing len mid-vector has no effect.
- Overflow:
  - Signed overflow of the ACC_W add sets acc_ovf. The flag stays set until the next vector's first beat.
  - Unsigned extended products can overflow only via the signed-sum rule.
- Wrap: with no optional feature the sum wraps modulo 2^ACC_W.
- Simultaneous events:
  - reset dominates everything.
  - z_valid in HOLD is not accepted; the upstream holds the beat.
  - Reset mid-vector discards the partial sum; no result is emitted.
- Stall: z_valid low mid-vector simply pauses accumulation; no timeout.

Optional Feature:
- Macro: RS_DSP_ACC_SAT_EN.
- Defined: on signed overflow, acc saturates to 2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow). acc_ovf is still set. Later adds proceed from the clamped value.
- Undefined: wrap-around arithmetic; acc_ovf indicates wrap only.

Decomposition:
- Shared package rs_dsp_pkg holds:
  - the state enum (IDLE, ACCUM, HOLD);
  - constant PROD_W=38;
  - an ext_prod function (signed/zero extension to ACC_W).
- One sub-module: rs_dsp_acc_add. It is a combinational ACC_W adder returning sum and ovf, and performs saturation when RS_DSP_ACC_SAT_EN is defined.
- FSM, counter and output registers live in the top module.

Test Plan:
- len=3; z_signed=1; products 5, -2, 10; acc_ready=1 -> acc_valid one cycle after the 3rd beat, acc_out=13, acc_ovf=0; z_ready=0 during HOLD.
- len=0; z_signed=0; single product 38'h3F_FFFF_FFFF -> treated as len 1; acc_out=0x3F_FFFF_FFFF (zero-extended, positive); acc_valid next cycle.
- len=2, ACC_W=39; z_signed=0; two products of 38'h3F_FFFF_FFFF:
  - macro undefined: acc_out wraps to 39'h7F_FFFF_FFFE, acc_ovf=1.
  - macro defined: acc_out=39'h3F_FFFF_FFFF, acc_ovf=1.
- Backpressure: complete a vector with acc_ready=0 for 5 cycles while z_valid=1 -> acc_out is held stable, no beats are accepted, and the next vector starts correctly after acc_ready pulses.
- Reset asserted after 2 of 4 beats -> acc_valid stays 0, acc_out=0. A following len=1 vector with product 7 yields acc_out=7.
- Gaps: len=4; z_valid toggles 1,0,0,1,1,0,1 with products 1, 2, 3, 4 -> acc_out=10, rem counts only accepted beats.
